// File: rtl/lif_neuron_array.sv
// ============================================================================
// Module   : lif_neuron_array
// Summary  : Time-multiplexed leaky integrate-and-fire neuron array with a
//            shared update datapath, a leak sweep FSM and spike output stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_neuron_array #(
  parameter int NUM_NEURONS     = 64,
  parameter int NEURON_ID_WIDTH = 6,
  parameter int DATA_WIDTH      = 16,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int THRESHOLD_WIDTH = 16,
  parameter int LEAK_WIDTH      = 8,
  parameter int REFRAC_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       s_syn_valid,
  output logic                       s_syn_ready,
  input  logic [NEURON_ID_WIDTH-1:0] s_syn_neuron_id,
  input  logic [WEIGHT_WIDTH-1:0]    s_syn_weight,
  input  logic                       s_syn_excitatory,
  input  logic                       timestep_tick,
  input  logic [THRESHOLD_WIDTH-1:0] threshold,
  input  logic [LEAK_WIDTH-1:0]      leak_rate,
  input  logic                       leak_mode,
  input  logic [REFRAC_WIDTH-1:0]    refractory_period,
  input  logic                       reset_mode,
  input  logic [DATA_WIDTH-1:0]      reset_potential,
  output logic                       m_spike_valid,
  input  logic                       m_spike_ready,
  output logic [NEURON_ID_WIDTH-1:0] m_spike_neuron_id,
  input  logic [NEURON_ID_WIDTH-1:0] rd_neuron_id,
  output logic [DATA_WIDTH-1:0]      rd_membrane,
  output logic                       busy,
  output logic [31:0]                spike_count
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  localparam logic [NEURON_ID_WIDTH-1:0] c_last = NEURON_ID_WIDTH'(NUM_NEURONS - 1);

  state_t                       r_state;
  logic [DATA_WIDTH-1:0]        r_mem [NUM_NEURONS];
  logic [REFRAC_WIDTH-1:0]      r_ref [NUM_NEURONS];
  logic                         r_pending;
  logic [NEURON_ID_WIDTH-1:0]   r_idx;
  logic                         r_spike_valid;
  logic [NEURON_ID_WIDTH-1:0]   r_spike_id;
  logic [31:0]                  r_spike_count;
  logic [DATA_WIDTH-1:0]        r_rd;

  logic                         w_syn_ready;
  logic                         w_accept;
  logic                         w_id_ok;
  logic                         w_rd_ok;
  logic                         w_tick;
  logic [DATA_WIDTH-1:0]        w_evt_v;
  logic [REFRAC_WIDTH-1:0]      w_evt_ref;
  logic [DATA_WIDTH:0]          w_sum;
  logic [DATA_WIDTH-1:0]        w_weight_ext;
  logic [DATA_WIDTH-1:0]        w_sat;
  logic [DATA_WIDTH-1:0]        w_sub;
  logic [DATA_WIDTH-1:0]        w_int;
  logic [DATA_WIDTH-1:0]        w_thr;
  logic                         w_evt_we;
  logic                         w_fire;
  logic [DATA_WIDTH-1:0]        w_post;
  logic [DATA_WIDTH-1:0]        w_sw_v;
  logic [REFRAC_WIDTH-1:0]      w_sw_ref;
  logic [DATA_WIDTH-1:0]        w_leak_ext;
  logic [DATA_WIDTH-1:0]        w_lin;
  logic [DATA_WIDTH-1:0]        w_exp;
  logic [DATA_WIDTH-1:0]        w_sw_next;

  // Ready never depends on the tick so an event and a tick can share a cycle.
  assign w_syn_ready = enable && (r_state == ST_IDLE) && (!r_spike_valid || m_spike_ready);
  assign w_accept    = s_syn_valid && w_syn_ready;
  assign w_id_ok     = (32'(s_syn_neuron_id) < NUM_NEURONS);
  assign w_rd_ok     = (32'(rd_neuron_id) < NUM_NEURONS);
  assign w_tick      = enable && timestep_tick;

  // Event datapath: integrate, saturate, then fire check on the new value.
  assign w_evt_v      = w_id_ok ? r_mem[s_syn_neuron_id] : '0;
  assign w_evt_ref    = w_id_ok ? r_ref[s_syn_neuron_id] : '0;
  assign w_weight_ext = DATA_WIDTH'(s_syn_weight);
  assign w_sum        = {1'b0, w_evt_v} + {1'b0, w_weight_ext};
  assign w_sat        = w_sum[DATA_WIDTH] ? '1 : w_sum[DATA_WIDTH-1:0];
  assign w_sub        = (w_evt_v >= w_weight_ext) ? (w_evt_v - w_weight_ext) : '0;
  assign w_int        = s_syn_excitatory ? w_sat : w_sub;
  assign w_thr        = DATA_WIDTH'(threshold);
  assign w_evt_we     = w_accept && w_id_ok && (w_evt_ref == '0);
  assign w_fire       = w_evt_we && (w_int >= w_thr);
  assign w_post       = !w_fire    ? w_int :
                        reset_mode ? (w_int - w_thr) : reset_potential;

  // Sweep datapath for the neuron at r_idx.
  assign w_sw_v     = r_mem[r_idx];
  assign w_sw_ref   = r_ref[r_idx];
  assign w_leak_ext = DATA_WIDTH'(leak_rate);
  assign w_lin      = (w_sw_v >= w_leak_ext) ? (w_sw_v - w_leak_ext) : '0;
  assign w_exp      = w_sw_v - (w_sw_v >> leak_rate[3:0]);
  assign w_sw_next  = leak_mode ? w_exp : w_lin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pending     <= 1'b0;
      r_idx         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_spike_count <= '0;
      r_rd          <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_mem[i] <= '0;
        r_ref[i] <= '0;
      end
    end else begin
      r_rd <= w_rd_ok ? r_mem[rd_neuron_id] : '0;

      if (r_spike_valid && m_spike_ready) begin
        r_spike_valid <= 1'b0;
      end

      if (w_evt_we) begin
        r_mem[s_syn_neuron_id] <= w_post;
      end
      if (w_fire) begin
        r_ref[s_syn_neuron_id] <= refractory_period;
        r_spike_valid          <= 1'b1;
        r_spike_id             <= s_syn_neuron_id;
        r_spike_count          <= r_spike_count + 32'd1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state   <= ST_SWEEP;
            r_idx     <= '0;
            r_pending <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (w_sw_ref != '0) begin
            r_ref[r_idx] <= w_sw_ref - REFRAC_WIDTH'(1);
          end else begin
            r_mem[r_idx] <= w_sw_next;
          end
          if (w_tick) begin
            r_pending <= 1'b1;
          end
          // Any ticks seen during a sweep collapse into exactly one rerun.
          if (r_idx == c_last) begin
            r_idx <= '0;
            if (r_pending || w_tick) begin
              r_pending <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_idx <= r_idx + NEURON_ID_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_syn_ready       = w_syn_ready;
  assign m_spike_valid     = r_spike_valid;
  assign m_spike_neuron_id = r_spike_id;
  assign rd_membrane       = r_rd;
  assign busy              = (r_state == ST_SWEEP);
  assign spike_count       = r_spike_count;

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
// ============================================================================
// Module   : tb_lif_neuron_array
// Summary  : Directed self-checking bench for lif_neuron_array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_neuron_array;

  localparam int NN  = 64;
  localparam int IDW = 6;
  localparam int DW  = 16;
  localparam int WW  = 8;
  localparam int TW  = 16;
  localparam int LW  = 8;
  localparam int RW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           s_syn_valid;
  logic           s_syn_ready;
  logic [IDW-1:0] s_syn_neuron_id;
  logic [WW-1:0]  s_syn_weight;
  logic           s_syn_excitatory;
  logic           timestep_tick;
  logic [TW-1:0]  threshold;
  logic [LW-1:0]  leak_rate;
  logic           leak_mode;
  logic [RW-1:0]  refractory_period;
  logic           reset_mode;
  logic [DW-1:0]  reset_potential;
  logic           m_spike_valid;
  logic           m_spike_ready;
  logic [IDW-1:0] m_spike_neuron_id;
  logic [IDW-1:0] rd_neuron_id;
  logic [DW-1:0]  rd_membrane;
  logic           busy;
  logic [31:0]    spike_count;

  int checks = 0;
  int errors = 0;

  lif_neuron_array #(
    .NUM_NEURONS(NN), .NEURON_ID_WIDTH(IDW), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .THRESHOLD_WIDTH(TW), .LEAK_WIDTH(LW), .REFRAC_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_syn_valid(s_syn_valid), .s_syn_ready(s_syn_ready),
    .s_syn_neuron_id(s_syn_neuron_id), .s_syn_weight(s_syn_weight),
    .s_syn_excitatory(s_syn_excitatory), .timestep_tick(timestep_tick),
    .threshold(threshold), .leak_rate(leak_rate), .leak_mode(leak_mode),
    .refractory_period(refractory_period), .reset_mode(reset_mode),
    .reset_potential(reset_potential),
    .m_spike_valid(m_spike_valid), .m_spike_ready(m_spike_ready),
    .m_spike_neuron_id(m_spike_neuron_id),
    .rd_neuron_id(rd_neuron_id), .rd_membrane(rd_membrane),
    .busy(busy), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers: all start and end on a falling edge.
  task automatic send_evt(input logic [IDW-1:0] id, input logic [WW-1:0] w, input logic exc);
    int n;
    s_syn_neuron_id  = id;
    s_syn_weight     = w;
    s_syn_excitatory = exc;
    s_syn_valid      = 1'b1;
    n = 0;
    while (!s_syn_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_syn_ready) begin
      errors++;
      $display("FAIL send_evt_timeout id=%0d: ready=%b required 1", id, s_syn_ready);
    end
    @(negedge clk);
    s_syn_valid = 1'b0;
  endtask

  task automatic read_mem(input logic [IDW-1:0] id, output logic [DW-1:0] v);
    rd_neuron_id = id;
    @(negedge clk);
    v = rd_membrane;
  endtask

  task automatic tick_and_wait();
    int n;
    timestep_tick = 1'b1;
    @(negedge clk);
    timestep_tick = 1'b0;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      errors++;
      $display("FAIL sweep_timeout: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (m_spike_valid !== 1'b0) begin errors++; $display("FAIL reset_spike_valid: got %b expected 0", m_spike_valid); end
    checks++; if (spike_count !== 32'd0) begin errors++; $display("FAIL reset_spike_count: got %0d expected 0", spike_count); end
    checks++; if (rd_membrane !== 16'h0000) begin errors++; $display("FAIL reset_rd_membrane: got %h expected 0000", rd_membrane); end
    checks++; if (s_syn_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", s_syn_ready); end
  endtask

  task automatic test_integrate_fire();
    logic [DW-1:0] v;
    for (int i = 0; i < 7; i++) send_evt(6'd3, 8'h20, 1'b1);
    read_mem(6'd3, v);
    checks++; if (v !== 16'h00E0) begin errors++; $display("FAIL integ_7_events: got %h expected 00e0", v); end
    checks++; if (m_spike_valid !== 1'b0) begin errors++; $display("FAIL integ_no_early_spike: got %b expected 0", m_spike_valid); end
    send_evt(6'd3, 8'h20, 1'b1);
    checks++;
    if (m_spike_valid !== 1'b1 || m_spike_neuron_id !== 6'd3) begin
      errors++; $display("FAIL fire_spike: got valid=%b id=%0d expected valid=1 id=3", m_spike_valid, m_spike_neuron_id);
    end
    checks++; if (spike_count !== 32'd1) begin errors++; $display("FAIL fire_count: got %0d expected 1", spike_count); end
    read_mem(6'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL fire_reset_potential: got %h expected 0000", v); end
  endtask

  task automatic test_refractory();
    logic [DW-1:0] v;
    send_evt(6'd3, 8'h20, 1'b1);
    send_evt(6'd4, 8'h20, 1'b1);
    read_mem(6'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL refrac_discard: got %h expected 0000", v); end
    read_mem(6'd4, v);
    checks++; if (v !== 16'h0020) begin errors++; $display("FAIL refrac_other_neuron: got %h expected 0020", v); end
    repeat (4) tick_and_wait();
    send_evt(6'd3, 8'h20, 1'b1);
    read_mem(6'd3, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL refrac_after_4_sweeps: got %h expected 0000", v); end
    tick_and_wait();
    send_evt(6'd3, 8'h20, 1'b1);
    read_mem(6'd3, v);
    checks++; if (v !== 16'h0020) begin errors++; $display("FAIL refrac_resume: got %h expected 0020", v); end
    read_mem(6'd4, v);
    checks++; if (v !== 16'h0020) begin errors++; $display("FAIL refrac_other_kept: got %h expected 0020", v); end
  endtask

  task automatic test_leak();
    logic [DW-1:0] v;
    for (int i = 0; i < 4; i++) send_evt(6'd5, 8'h20, 1'b1);
    send_evt(6'd6, 8'h05, 1'b1);
    leak_mode = 1'b0;
    leak_rate = 8'h10;
    tick_and_wait();
    read_mem(6'd5, v);
    checks++; if (v !== 16'h0070) begin errors++; $display("FAIL leak_linear: got %h expected 0070", v); end
    read_mem(6'd6, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL leak_linear_floor: got %h expected 0000", v); end
    send_evt(6'd5, 8'h10, 1'b1);
    leak_mode = 1'b1;
    leak_rate = 8'h02;
    tick_and_wait();
    read_mem(6'd5, v);
    checks++; if (v !== 16'h0060) begin errors++; $display("FAIL leak_exp: got %h expected 0060", v); end
    read_mem(6'd3, v);
    checks++; if (v !== 16'h000C) begin errors++; $display("FAIL leak_exp_small: got %h expected 000c", v); end
    leak_mode = 1'b0;
    leak_rate = 8'h00;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v;
    threshold     = 16'h0040;
    m_spike_ready = 1'b0;
    send_evt(6'd7, 8'h40, 1'b1);
    checks++;
    if (m_spike_valid !== 1'b1 || m_spike_neuron_id !== 6'd7 || s_syn_ready !== 1'b0) begin
      errors++; $display("FAIL bp_first_spike: got valid=%b id=%0d ready=%b expected 1 7 0",
                         m_spike_valid, m_spike_neuron_id, s_syn_ready);
    end
    s_syn_neuron_id  = 6'd8;
    s_syn_weight     = 8'h40;
    s_syn_excitatory = 1'b1;
    s_syn_valid      = 1'b1;
    repeat (2) @(negedge clk);
    read_mem(6'd8, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL bp_event_held: got %h expected 0000", v); end
    checks++;
    if (m_spike_valid !== 1'b1 || m_spike_neuron_id !== 6'd7 || s_syn_ready !== 1'b0 || spike_count !== 32'd2) begin
      errors++; $display("FAIL bp_spike_stable: got valid=%b id=%0d ready=%b count=%0d expected 1 7 0 2",
                         m_spike_valid, m_spike_neuron_id, s_syn_ready, spike_count);
    end
    m_spike_ready = 1'b1;
    @(negedge clk);
    s_syn_valid = 1'b0;
    checks++;
    if (m_spike_valid !== 1'b1 || m_spike_neuron_id !== 6'd8 || spike_count !== 32'd3) begin
      errors++; $display("FAIL bp_second_spike: got valid=%b id=%0d count=%0d expected 1 8 3",
                         m_spike_valid, m_spike_neuron_id, spike_count);
    end
    @(negedge clk);
    checks++; if (m_spike_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", m_spike_valid); end
    threshold = 16'h0100;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    int cnt;
    leak_mode        = 1'b0;
    leak_rate        = 8'h04;
    s_syn_neuron_id  = 6'd9;
    s_syn_weight     = 8'h10;
    s_syn_excitatory = 1'b1;
    s_syn_valid      = 1'b1;
    timestep_tick    = 1'b1;
    @(negedge clk);
    s_syn_valid   = 1'b0;
    timestep_tick = 1'b0;
    cnt = 0;
    while (busy && cnt < 400) begin
      cnt++;
      timestep_tick = (cnt == 5);
      @(negedge clk);
    end
    timestep_tick = 1'b0;
    checks++; if (cnt !== 2 * NN) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", cnt, 2 * NN); end
    checks++; if (s_syn_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %b expected 1", s_syn_ready); end
    read_mem(6'd9, v);
    checks++; if (v !== 16'h0008) begin errors++; $display("FAIL b2b_event_before_sweep: got %h expected 0008", v); end
    leak_rate = 8'h00;
  endtask

  task automatic test_saturation();
    logic [DW-1:0] v;
    threshold  = 16'hFFFF;
    reset_mode = 1'b1;
    for (int i = 0; i < 256; i++) send_evt(6'd10, 8'hFF, 1'b1);
    send_evt(6'd10, 8'hF0, 1'b1);
    read_mem(6'd10, v);
    checks++; if (v !== 16'hFFF0) begin errors++; $display("FAIL sat_preload: got %h expected fff0", v); end
    send_evt(6'd10, 8'h20, 1'b1);
    checks++;
    if (m_spike_valid !== 1'b1 || m_spike_neuron_id !== 6'd10) begin
      errors++; $display("FAIL sat_spike: got valid=%b id=%0d expected 1 10", m_spike_valid, m_spike_neuron_id);
    end
    read_mem(6'd10, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL sat_subtract_reset: got %h expected 0000", v); end
    threshold = 16'h0100;
    send_evt(6'd11, 8'hF0, 1'b1);
    send_evt(6'd11, 8'h20, 1'b1);
    checks++;
    if (m_spike_valid !== 1'b1 || m_spike_neuron_id !== 6'd11) begin
      errors++; $display("FAIL mode1_spike: got valid=%b id=%0d expected 1 11", m_spike_valid, m_spike_neuron_id);
    end
    read_mem(6'd11, v);
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL mode1_residue: got %h expected 0010", v); end
    send_evt(6'd12, 8'h10, 1'b1);
    send_evt(6'd12, 8'h20, 1'b0);
    read_mem(6'd12, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL inhib_floor: got %h expected 0000", v); end
    checks++; if (spike_count !== 32'd5) begin errors++; $display("FAIL total_spikes: got %0d expected 5", spike_count); end
  endtask

  task automatic test_reset_mid_sweep();
    logic [DW-1:0] v;
    timestep_tick = 1'b1;
    @(negedge clk);
    timestep_tick = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsweep_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_abort_busy: got %b expected 0", busy); end
    checks++; if (spike_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", spike_count); end
    read_mem(6'd5, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_mem5: got %h expected 0000", v); end
    read_mem(6'd11, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_mem11: got %h expected 0000", v); end
  endtask

  initial begin
    rst               = 1'b1;
    enable            = 1'b1;
    s_syn_valid       = 1'b0;
    s_syn_neuron_id   = '0;
    s_syn_weight      = '0;
    s_syn_excitatory  = 1'b1;
    timestep_tick     = 1'b0;
    threshold         = 16'h0100;
    leak_rate         = 8'h00;
    leak_mode         = 1'b0;
    refractory_period = 8'd5;
    reset_mode        = 1'b0;
    reset_potential   = 16'h0000;
    m_spike_ready     = 1'b1;
    rd_neuron_id      = 6'd3;

    test_reset();
    test_integrate_fire();
    test_refractory();
    test_leak();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid_sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
